// File: rtl/cpu_bus_responder.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_bus_responder
//  Purpose  : Return path of the CPU memory bus. Takes the one-hot region
//             enables from address decode, inserts the wait states for the
//             selected region, then returns a single-cycle cpu_mem_ready
//             pulse together with the registered read data.
//  Revision : 1.0  initial release
//
//  Parameters
//    VDP_LATENCY     cycles from request to ready for VDP accesses (1..15)
//    TIMEOUT_CYCLES  watchdog limit in cycles (2..255), BUS_TIMEOUT_EN only
//
//  Optional feature
//    BUS_TIMEOUT_EN  when defined, adds an 8-bit watchdog that force-completes
//                    a stalled request with 0xFFFFFFFF and sets a sticky
//                    bus_error. When undefined, bus_error is constant 0.
//
//  Ports
//    clk                   in   system clock
//    reset                 in   synchronous active-high reset
//    cpu_mem_valid         in   CPU request pending
//    cpu_wstrb[3:0]        in   write strobes, nonzero means write
//    *_en                  in   region enables (one-hot or all zero)
//    *_read_data           in   region read data (narrow ones zero-extended)
//    flash_read_ready      in   flash word valid (variable latency)
//    cpu_mem_ready         out  one-cycle completion pulse
//    cpu_mem_rdata[31:0]   out  read data, non-zero only while ready is high
//    bus_error             out  sticky timeout flag
// ============================================================================
module cpu_bus_responder #(
    parameter int VDP_LATENCY    = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_mem_valid,
    input  logic [3:0]  cpu_wstrb,
    input  logic        cpu_ram_en,
    input  logic        bootloader_en,
    input  logic        vdp_en,
    input  logic        status_en,
    input  logic        dsp_en,
    input  logic        pad_en,
    input  logic        flash_read_en,
    input  logic        cop_ram_en,
    input  logic [31:0] cpu_ram_read_data,
    input  logic [31:0] bootloader_read_data,
    input  logic [31:0] flash_read_data,
    input  logic [15:0] vdp_read_data,
    input  logic [15:0] dsp_read_data,
    input  logic [15:0] pad_read_data,
    input  logic [7:0]  status_read_data,
    input  logic        flash_read_ready,
    output logic        cpu_mem_ready,
    output logic [31:0] cpu_mem_rdata,
    output logic        bus_error
);

    // ------------------------------------------------------------------------
    // Parameter legality
    // ------------------------------------------------------------------------
    if ((VDP_LATENCY < 1) || (VDP_LATENCY > 15)) begin : g_bad_vdp_latency
        $error("cpu_bus_responder: VDP_LATENCY must be in 1..15");
    end

    if ((TIMEOUT_CYCLES < 2) || (TIMEOUT_CYCLES > 255)) begin : g_bad_timeout
        $error("cpu_bus_responder: TIMEOUT_CYCLES must be in 2..255");
    end

    // ------------------------------------------------------------------------
    // Encodings
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_IDLE       = 2'd0;
    localparam logic [1:0] c_COUNT      = 2'd1;
    localparam logic [1:0] c_FLASH_WAIT = 2'd2;
    localparam logic [1:0] c_ACK        = 2'd3;

    localparam logic [2:0] c_REG_RAM    = 3'd0;
    localparam logic [2:0] c_REG_BOOT   = 3'd1;
    localparam logic [2:0] c_REG_VDP    = 3'd2;
    localparam logic [2:0] c_REG_STATUS = 3'd3;
    localparam logic [2:0] c_REG_DSP    = 3'd4;
    localparam logic [2:0] c_REG_PAD    = 3'd5;
    localparam logic [2:0] c_REG_COP    = 3'd6;
    localparam logic [2:0] c_REG_FLASH  = 3'd7;

    localparam logic [3:0] c_VDP_LOAD   = 4'(VDP_LATENCY - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]  r_state;
    logic [2:0]  r_sel;
    logic        r_write;
    logic [3:0]  r_cnt;
    logic [31:0] r_rdata;

    logic [1:0]  w_state_nxt;
    logic [2:0]  w_sel_nxt;
    logic        w_write_nxt;
    logic [3:0]  w_cnt_nxt;
    logic [31:0] w_rdata_nxt;

    logic        w_any_en;
    logic [2:0]  w_dec_sel;
    logic [31:0] w_region_data;
    logic        w_timeout;

    assign w_any_en = cpu_ram_en | bootloader_en | vdp_en | status_en |
                      dsp_en | pad_en | flash_read_en | cop_ram_en;

    // Several enables at once is illegal; a fixed priority keeps the
    // outcome deterministic anyway.
    always_comb begin
        w_dec_sel = c_REG_COP;
        if (flash_read_en)      w_dec_sel = c_REG_FLASH;
        else if (cpu_ram_en)    w_dec_sel = c_REG_RAM;
        else if (bootloader_en) w_dec_sel = c_REG_BOOT;
        else if (vdp_en)        w_dec_sel = c_REG_VDP;
        else if (status_en)     w_dec_sel = c_REG_STATUS;
        else if (dsp_en)        w_dec_sel = c_REG_DSP;
        else if (pad_en)        w_dec_sel = c_REG_PAD;
        else                    w_dec_sel = c_REG_COP;
    end

    // Read data of the latched region, zero-extended. cop_ram is write-only.
    always_comb begin
        w_region_data = 32'h0;
        case (r_sel)
            c_REG_RAM:    w_region_data = cpu_ram_read_data;
            c_REG_BOOT:   w_region_data = bootloader_read_data;
            c_REG_VDP:    w_region_data = {16'h0, vdp_read_data};
            c_REG_STATUS: w_region_data = {24'h0, status_read_data};
            c_REG_DSP:    w_region_data = {16'h0, dsp_read_data};
            c_REG_PAD:    w_region_data = {16'h0, pad_read_data};
            c_REG_FLASH:  w_region_data = flash_read_data;
            default:      w_region_data = 32'h0;
        endcase
    end

    // ------------------------------------------------------------------------
    // Optional watchdog
    // ------------------------------------------------------------------------
`ifdef BUS_TIMEOUT_EN
    logic [7:0] r_wd;
    logic       r_bus_err;

    // Counts every cycle a request is outstanding (including an unmapped
    // request parked in IDLE); fires on the cycle the count equals the limit.
    assign w_timeout = cpu_mem_valid && (r_state != c_ACK) &&
                       (r_wd == 8'(TIMEOUT_CYCLES));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wd      <= 8'h0;
            r_bus_err <= 1'b0;
        end else begin
            if ((r_state == c_ACK) || ((r_state == c_IDLE) && !cpu_mem_valid)) begin
                r_wd <= 8'h0;
            end else if (cpu_mem_valid) begin
                r_wd <= r_wd + 8'd1;
            end
            if (w_timeout) begin
                r_bus_err <= 1'b1;
            end
        end
    end

    assign bus_error = r_bus_err;
`else
    assign w_timeout = 1'b0;
    assign bus_error = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_write_nxt = r_write;
        w_cnt_nxt   = r_cnt;
        w_rdata_nxt = r_rdata;

        case (r_state)
            c_IDLE: begin
                w_rdata_nxt = 32'h0;
                // An unmapped request (valid with no enable) stays parked here.
                if (cpu_mem_valid && w_any_en) begin
                    w_sel_nxt   = w_dec_sel;
                    w_write_nxt = (cpu_wstrb != 4'h0);
                    if (flash_read_en) begin
                        w_state_nxt = c_FLASH_WAIT;
                        w_cnt_nxt   = 4'h0;
                    end else begin
                        w_state_nxt = c_COUNT;
                        w_cnt_nxt   = (w_dec_sel == c_REG_VDP) ? c_VDP_LOAD : 4'h0;
                    end
                end
            end

            c_COUNT: begin
                // A withdrawn request aborts silently, even on the last count.
                if (!cpu_mem_valid) begin
                    w_state_nxt = c_IDLE;
                    w_cnt_nxt   = 4'h0;
                end else if (r_cnt == 4'h0) begin
                    w_state_nxt = c_ACK;
                    w_rdata_nxt = r_write ? 32'h0 : w_region_data;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end

            c_FLASH_WAIT: begin
                if (!cpu_mem_valid) begin
                    w_state_nxt = c_IDLE;
                end else if (flash_read_ready) begin
                    w_state_nxt = c_ACK;
                    w_rdata_nxt = r_write ? 32'h0 : flash_read_data;
                end
            end

            c_ACK: begin
                // One turnaround cycle; cpu_mem_valid is not looked at here.
                w_state_nxt = c_IDLE;
                w_rdata_nxt = 32'h0;
            end

            default: begin
                w_state_nxt = c_IDLE;
                w_cnt_nxt   = 4'h0;
                w_rdata_nxt = 32'h0;
            end
        endcase

        // Watchdog completion overrides any normal progress.
        if (w_timeout) begin
            w_state_nxt = c_ACK;
            w_cnt_nxt   = 4'h0;
            w_rdata_nxt = 32'hFFFF_FFFF;
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
            r_sel   <= c_REG_RAM;
            r_write <= 1'b0;
            r_cnt   <= 4'h0;
            r_rdata <= 32'h0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_write <= w_write_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rdata <= w_rdata_nxt;
        end
    end

    assign cpu_mem_ready = (r_state == c_ACK);
    assign cpu_mem_rdata = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_cpu_bus_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cpu_bus_responder
//  Purpose  : Self-checking bench for cpu_bus_responder. A transaction-level
//             model predicts, per request, the cycle of the ready pulse and
//             the data it carries; a compare process checks ready, rdata and
//             bus_error on every cycle against that prediction.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cpu_bus_responder;

    localparam int L = 4;
    localparam int T = 16;

    // region indices used by the bench
    localparam int R_RAM = 0, R_BOOT = 1, R_VDP = 2, R_STATUS = 3;
    localparam int R_DSP = 4, R_PAD = 5, R_COP = 6, R_FLASH = 7, R_NONE = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_mem_valid;
    logic [3:0]  cpu_wstrb;
    logic        cpu_ram_en, bootloader_en, vdp_en, status_en;
    logic        dsp_en, pad_en, flash_read_en, cop_ram_en;
    logic [31:0] cpu_ram_read_data, bootloader_read_data, flash_read_data;
    logic [15:0] vdp_read_data, dsp_read_data, pad_read_data;
    logic [7:0]  status_read_data;
    logic        flash_read_ready;
    logic        cpu_mem_ready;
    logic [31:0] cpu_mem_rdata;
    logic        bus_error;

    cpu_bus_responder #(
        .VDP_LATENCY    (L),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .cpu_mem_valid        (cpu_mem_valid),
        .cpu_wstrb            (cpu_wstrb),
        .cpu_ram_en           (cpu_ram_en),
        .bootloader_en        (bootloader_en),
        .vdp_en               (vdp_en),
        .status_en            (status_en),
        .dsp_en               (dsp_en),
        .pad_en               (pad_en),
        .flash_read_en        (flash_read_en),
        .cop_ram_en           (cop_ram_en),
        .cpu_ram_read_data    (cpu_ram_read_data),
        .bootloader_read_data (bootloader_read_data),
        .flash_read_data      (flash_read_data),
        .vdp_read_data        (vdp_read_data),
        .dsp_read_data        (dsp_read_data),
        .pad_read_data        (pad_read_data),
        .status_read_data     (status_read_data),
        .flash_read_ready     (flash_read_ready),
        .cpu_mem_ready        (cpu_mem_ready),
        .cpu_mem_rdata        (cpu_mem_rdata),
        .bus_error            (bus_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    // model state: cycle -> data expected with the ready pulse
    logic [31:0] exp_data [int];
    logic        exp_err = 1'b0;
    bit          chk_en  = 1'b0;
    bit          fixed   = 1'b0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, want, cyc);
        end
    endtask

    // per-cycle compare against the model
    always @(negedge clk) begin
        if (chk_en) begin
            if (exp_data.exists(cyc)) begin
                check("ready", {31'b0, cpu_mem_ready}, 32'd1);
                check("rdata", cpu_mem_rdata, exp_data[cyc]);
            end else begin
                check("ready_idle", {31'b0, cpu_mem_ready}, 32'd0);
                check("rdata_idle", cpu_mem_rdata, 32'd0);
            end
            check("bus_error", {31'b0, bus_error}, {31'b0, exp_err});
        end
    end

    always @(negedge clk) begin
        if (!reset && cpu_mem_valid)
            assert ($onehot0({cpu_ram_en, bootloader_en, vdp_en, status_en,
                              dsp_en, pad_en, flash_read_en, cop_ram_en}))
            else $error("illegal: multiple region enables");
    end

    task automatic set_en(input int r);
        cpu_ram_en    = (r == R_RAM);
        bootloader_en = (r == R_BOOT);
        vdp_en        = (r == R_VDP);
        status_en     = (r == R_STATUS);
        dsp_en        = (r == R_DSP);
        pad_en        = (r == R_PAD);
        cop_ram_en    = (r == R_COP);
        flash_read_en = (r == R_FLASH);
    endtask

    task automatic rand_data();
        cpu_ram_read_data    = $urandom;
        bootloader_read_data = $urandom;
        flash_read_data      = $urandom;
        vdp_read_data        = 16'($urandom);
        dsp_read_data        = 16'($urandom);
        pad_read_data        = 16'($urandom);
        status_read_data     = 8'($urandom);
    endtask

    function automatic logic [31:0] region_value(input int r);
        case (r)
            R_RAM:    return cpu_ram_read_data;
            R_BOOT:   return bootloader_read_data;
            R_VDP:    return {16'h0, vdp_read_data};
            R_STATUS: return {24'h0, status_read_data};
            R_DSP:    return {16'h0, dsp_read_data};
            R_PAD:    return {16'h0, pad_read_data};
            R_FLASH:  return flash_read_data;
            default:  return 32'h0;
        endcase
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            cpu_mem_valid = 1'b0; cpu_wstrb = 4'h0; set_en(R_NONE);
            flash_read_ready = 1'b0;
            if (!fixed) rand_data();
        end
    endtask

    // One request. Completion cycle per the timing rules: fixed regions 2,
    // VDP L+1, flash one after the ready sample. abort_at>0 withdraws valid
    // at that offset; for flash a late flash_read_ready follows next cycle.
    task automatic run_txn(input int r, input bit wr, input int fd, input int abort_at,
                           input int next_r, input bit use_lit, input logic [31:0] lit,
                           input string nm);
        int c0;
        int ackc;
        int i;
        @(posedge clk); #1;
        c0 = cyc;
        if (r == R_FLASH)    ackc = c0 + fd + 1;
        else if (r == R_VDP) ackc = c0 + L + 1;
        else                 ackc = c0 + 2;
        cpu_mem_valid = 1'b1;
        cpu_wstrb     = wr ? 4'($urandom_range(1, 15)) : 4'h0;
        set_en(r);
        i = 0;
        forever begin
            if (!fixed) rand_data();
            flash_read_ready = (r == R_FLASH) && (i == fd);
            if (abort_at > 0 && i == abort_at) begin
                cpu_mem_valid = 1'b0; cpu_wstrb = 4'h0; set_en(R_NONE);
            end
            if (abort_at > 0 && i == abort_at + 1) return;
            if (abort_at == 0 && c0 + i == ackc - 1)
                exp_data[ackc] = (wr || r == R_COP) ? 32'h0 : region_value(r);
            if (abort_at == 0 && c0 + i == ackc) begin
                // a request presented during ACK must be ignored until IDLE
                cpu_wstrb = 4'h0;
                if (next_r >= 0) begin
                    cpu_mem_valid = 1'b1; set_en(next_r);
                end else begin
                    cpu_mem_valid = 1'b0; set_en(R_NONE);
                end
                if (use_lit) begin
                    @(negedge clk);
                    check({nm, "_ready"}, {31'b0, cpu_mem_ready}, 32'd1);
                    check({nm, "_rdata"}, cpu_mem_rdata, lit);
                end
                return;
            end
            @(posedge clk); #1;
            i++;
        end
    endtask

    task automatic reset_mid_flash();
        @(posedge clk); #1;
        cpu_mem_valid = 1'b1; cpu_wstrb = 4'h0; set_en(R_FLASH); flash_read_ready = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        reset = 1'b1;                      // cycle 3 of the flash wait
        @(posedge clk); #1;
        reset = 1'b0; exp_err = 1'b0;
        set_en(R_NONE); flash_read_ready = 1'b1;   // late ready while parked
        @(negedge clk);
        check("rst_flash_ready", {31'b0, cpu_mem_ready}, 32'd0);
        check("rst_flash_rdata", cpu_mem_rdata, 32'd0);
        check("rst_flash_err", {31'b0, bus_error}, 32'd0);
        @(posedge clk); #1;
        cpu_mem_valid = 1'b0; flash_read_ready = 1'b0;
        idle(3);
    endtask

    task automatic unmapped_test();
        int c0;
        @(posedge clk); #1;
        c0 = cyc;
        cpu_mem_valid = 1'b1; cpu_wstrb = 4'h0; set_en(R_NONE); flash_read_ready = 1'b0;
`ifdef BUS_TIMEOUT_EN
        exp_data[c0 + T + 1] = 32'hFFFF_FFFF;
        while (cyc < c0 + T + 1) begin @(posedge clk); #1; end
        exp_err = 1'b1;
        cpu_mem_valid = 1'b0;
        @(negedge clk);
        check("timeout_ready", {31'b0, cpu_mem_ready}, 32'd1);
        check("timeout_rdata", cpu_mem_rdata, 32'hFFFF_FFFF);
        check("timeout_err", {31'b0, bus_error}, 32'd1);
        run_txn(R_RAM, 1'b0, 1, 0, -1, 1'b0, 32'h0, "post_timeout");
        idle(2);
        @(negedge clk);
        check("err_sticky", {31'b0, bus_error}, 32'd1);
`else
        repeat (1000) begin @(posedge clk); #1; end
        cpu_mem_valid = 1'b0;
        @(negedge clk);
        check("unmapped_no_ready", {31'b0, cpu_mem_ready}, 32'd0);
        check("unmapped_err", {31'b0, bus_error}, 32'd0);
`endif
        idle(1);
    endtask

    initial begin
        int rg [80];
        reset = 1'b1;
        cpu_mem_valid = 1'b0; cpu_wstrb = 4'h0; flash_read_ready = 1'b0;
        set_en(R_NONE);
        rand_data();
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(negedge clk);
        check("reset_ready", {31'b0, cpu_mem_ready}, 32'd0);
        check("reset_rdata", cpu_mem_rdata, 32'd0);
        check("reset_err", {31'b0, bus_error}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // directed cases with fixed data
        fixed = 1'b1;
        cpu_ram_read_data = 32'h1234_5678;
        vdp_read_data     = 16'hBEEF;
        flash_read_data   = 32'hCAFE_F00D;
        pad_read_data     = 16'h00A5;
        idle(1);
        run_txn(R_RAM,   1'b0, 1, 0, -1, 1'b1, 32'h1234_5678, "ram_read");
        idle(1);
        run_txn(R_VDP,   1'b0, 1, 0, -1, 1'b1, 32'h0000_BEEF, "vdp_read");
        run_txn(R_VDP,   1'b1, 1, 0, -1, 1'b1, 32'h0000_0000, "vdp_write");
        idle(1);
        run_txn(R_FLASH, 1'b0, 7, 0, R_RAM, 1'b1, 32'hCAFE_F00D, "flash_read");
        run_txn(R_RAM,   1'b0, 1, 0, -1, 1'b1, 32'h1234_5678, "b2b_ram");
        idle(1);
        run_txn(R_VDP,   1'b0, 1, 2, -1, 1'b0, 32'h0, "vdp_abort");
        run_txn(R_PAD,   1'b0, 1, 0, -1, 1'b1, 32'h0000_00A5, "pad_read");
        run_txn(R_COP,   1'b0, 1, 0, -1, 1'b1, 32'h0000_0000, "cop_read");
        idle(2);
        unmapped_test();
        reset_mid_flash();

        // randomized traffic
        fixed = 1'b0;
        foreach (rg[k]) rg[k] = $urandom_range(0, 7);
        for (int k = 0; k < 80; k++) begin
            int fd, ab, gap, nx;
            bit wr;
            wr  = 1'($urandom_range(0, 1));
            fd  = $urandom_range(1, 10);
            ab  = 0;
            if ($urandom_range(0, 7) == 0) begin
                if (rg[k] == R_FLASH) begin
                    ab = $urandom_range(1, 5);
                    fd = ab + 1;
                end else if (rg[k] == R_VDP) begin
                    ab = $urandom_range(1, L);
                end else begin
                    ab = 1;
                end
            end
            gap = $urandom_range(0, 2);
            nx  = (ab == 0 && gap == 0 && k + 1 < 80) ? rg[k + 1] : -1;
            run_txn(rg[k], wr, fd, ab, nx, 1'b0, 32'h0, "rand");
            idle(gap);
        end
        idle(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
